alu_ctrl_issue: RTL

- ID→EX issue stage for the single-cycle/pipelined RV32 core. It drives the ALU's 4-bit control interface.
- It decodes the instruction fields into the ALU control code and the operand-select signal, then registers them into the ID/EX boundary with a valid flag.
- `mul` is treated as multi-cycle: issue is held for MUL_LAT cycles and a completion pulse is produced.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_ctrl_dec.sv | 50 +++++
 rtl/alu_ctrl_issue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control constants: op codes, RV32 opcode/funct7 values and issue FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_XOR = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_MUL = 1'b1;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       src;
        logic       is_mul;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32 decode of opcode/funct3/funct7 into ALU control, operand select and mul/legal flags.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [3:0]  o_ctrl,
    output logic        o_src,
    output logic        o_is_mul,
    output logic        o_legal
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_unused;
    dec_t       w_dec;

    assign w_op     = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    // Register and immediate fields play no part in ALU control selection.
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        w_dec = '{ctrl: ALU_AND, src: 1'b0, is_mul: 1'b0, legal: 1'b0};
        case (w_op)
            OP_R: begin
                if (w_f7 == F7_BASE && w_f3 == 3'b000) w_dec = '{ALU_ADD, 1'b0, 1'b0, 1'b1};
                else if (w_f7 == F7_ALT  && w_f3 == 3'b000) w_dec = '{ALU_SUB, 1'b0, 1'b0, 1'b1};
                else if (w_f7 == F7_BASE && w_f3 == 3'b111) w_dec = '{ALU_AND, 1'b0, 1'b0, 1'b1};
                else if (w_f7 == F7_BASE && w_f3 == 3'b100) w_dec = '{ALU_XOR, 1'b0, 1'b0, 1'b1};
                else if (w_f7 == F7_BASE && w_f3 == 3'b001) w_dec = '{ALU_SLL, 1'b0, 1'b0, 1'b1};
                else if (w_f7 == F7_MUL  && w_f3 == 3'b000) w_dec = '{ALU_MUL, 1'b0, 1'b1, 1'b1};
            end
            OP_I: begin
                if (w_f3 == 3'b000) w_dec = '{ALU_ADD, 1'b1, 1'b0, 1'b1};
                else if (w_f3 == 3'b101 && w_f7 == F7_ALT) w_dec = '{ALU_SRA, 1'b1, 1'b0, 1'b1};
            end
            OP_LD, OP_ST: w_dec = '{ALU_ADD, 1'b1, 1'b0, 1'b1};
            OP_BR:        w_dec = '{ALU_SUB, 1'b0, 1'b0, 1'b1};
            default:      w_dec = '{ALU_AND, 1'b0, 1'b0, 1'b0};
        endcase
    end

    assign o_ctrl   = w_dec.ctrl;
    assign o_src    = w_dec.src;
    assign o_is_mul = w_dec.is_mul;
    assign o_legal  = w_dec.legal;

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID->EX issue register with multi-cycle mul hold and completion pulse.
// Optional ILLEGAL_TRAP_EN: illegal accepts issue ALU_ILL and raise illegal_o instead of being dropped.
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [31:0] instr_i,
    input  logic       flush_i,
    output logic       ready_o,
    output logic       valid_o,
    output logic [3:0] ALUCtrl_o,
    output logic       ALUSrc_o,
    output logic       mul_busy_o,
`ifdef ILLEGAL_TRAP_EN
    output logic       illegal_o,
`endif
    output logic       mul_done_o
);

    logic [3:0]       w_ctrl;
    logic             w_src;
    logic             w_is_mul;
    logic             w_legal;
    logic             w_ready;
    logic             w_accept;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [3:0]       r_ctrl;
    logic             r_src;
    logic             r_busy;
    logic             r_done;
`ifdef ILLEGAL_TRAP_EN
    logic             r_illegal;
`endif

    alu_ctrl_dec u_dec (
        .i_instr  (instr_i),
        .o_ctrl   (w_ctrl),
        .o_src    (w_src),
        .o_is_mul (w_is_mul),
        .o_legal  (w_legal)
    );

    // The final mul cycle (counter drained) already behaves like RUN.
    assign w_ready  = (r_state == ST_RUN) || (r_cnt == '0);
    assign w_accept = valid_i && w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ctrl    <= 4'b0000;
            r_src     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else if (flush_i) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else if (!w_ready) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
        end else begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
            if (w_accept && w_legal) begin
                r_valid <= 1'b1;
                r_ctrl  <= w_ctrl;
                r_src   <= w_src;
                if (w_is_mul) begin
                    r_busy  <= 1'b1;
                    r_cnt   <= CNT_W'(MUL_LAT - 1);
                    r_done  <= (MUL_LAT == 1);
                    r_state <= (MUL_LAT == 1) ? ST_RUN : ST_MUL;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            else if (w_accept) begin
                r_valid   <= 1'b1;
                r_ctrl    <= ALU_ILL;
                r_src     <= 1'b0;
                r_illegal <= 1'b1;
            end
`endif
        end
    end

    assign ready_o    = w_ready;
    assign valid_o    = r_valid;
    assign ALUCtrl_o  = r_ctrl;
    assign ALUSrc_o   = r_src;
    assign mul_busy_o = r_busy;
    assign mul_done_o = r_done;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_o  = r_illegal;
`endif

endmodule
